// File: rtl/counter_driver_if.sv
// Handshake bundle between counter_driver and its environment.
// master = driver side; slave = controller/counter side. err needs COUNTER_DRIVER_WDOG_EN.
interface counter_driver_if #(
  parameter int CW = 16
);
  logic          go;
  logic          stall;
  logic          cnt_start;
  logic          cnt_ena;
  logic          cnt_done;
  logic [CW-1:0] outer_cnt;
  logic          busy;
  logic          done;
`ifdef COUNTER_DRIVER_WDOG_EN
  logic          err;

  modport master (
    input  go, stall, cnt_done,
    output cnt_start, cnt_ena, outer_cnt,
    output busy, done, err
  );

  modport slave (
    output go, stall, cnt_done,
    input  cnt_start, cnt_ena, outer_cnt,
    input  busy, done, err
  );
`else
  modport master (
    input  go, stall, cnt_done,
    output cnt_start, cnt_ena, outer_cnt,
    output busy, done
  );

  modport slave (
    output go, stall, cnt_done,
    input  cnt_start, cnt_ena, outer_cnt,
    input  busy, done
  );
`endif
endinterface

// File: rtl/counter_driver.sv
// Counter initiator: runs OUTER_MAX start/ena/done sweeps per go, GAP idle cycles apart.
// Ports: clk, rst (async active-low), bus (go/stall/cnt_* /outer_cnt/busy/done[/err]); watchdog via COUNTER_DRIVER_WDOG_EN.
module counter_driver #(
  parameter int CW        = 16,
  parameter int OUTER_MAX = 4,
  parameter int GAP       = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  counter_driver_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(OUTER_MAX - 1);
  localparam logic [CW-1:0] GAPV = CW'(GAP);
  localparam logic [CW-1:0] ONE  = CW'(1);

  if (OUTER_MAX < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("counter_driver: OUTER_MAX and TIMEOUT must be >= 1");
  end

  state_t        r_state;
  logic          r_start;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_outer;
  logic [CW-1:0] r_gap;
  logic          w_ena;

`ifdef COUNTER_DRIVER_WDOG_EN
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] r_wd;
  logic          r_err;
  assign bus.err = r_err;
`endif

  // Enable is the only combinational output so stall acts in the same cycle.
  assign w_ena         = (r_state == S_RUN) & ~bus.stall;
  assign bus.cnt_ena   = w_ena;
  assign bus.cnt_start = r_start;
  assign bus.outer_cnt = r_outer;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_outer <= '0;
      r_gap   <= '0;
`ifdef COUNTER_DRIVER_WDOG_EN
      r_wd    <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.go) begin
            r_state <= S_START;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_RUN;
`ifdef COUNTER_DRIVER_WDOG_EN
          r_wd    <= '0;
`endif
        end
        S_RUN: begin
          // cnt_done wins over stall and over the watchdog.
          if (bus.cnt_done) begin
`ifdef COUNTER_DRIVER_WDOG_EN
            r_wd <= '0;
`endif
            if (r_outer == LAST) begin
              r_state <= S_FIN;
            end else begin
              r_outer <= r_outer + ONE;
              if (GAP > 0) begin
                r_state <= S_GAP;
                r_gap   <= GAPV;
              end else begin
                r_state <= S_START;
                r_start <= 1'b1;
              end
            end
          end
`ifdef COUNTER_DRIVER_WDOG_EN
          else if (w_ena) begin
            if (r_wd == WD_LAST) begin
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_wd <= r_wd + ONE;
            end
          end
`endif
        end
        S_GAP: begin
          // Loaded with GAP, so this state lasts exactly GAP cycles.
          if (r_gap <= ONE) begin
            r_state <= S_START;
            r_start <= 1'b1;
          end else begin
            r_gap <= r_gap - ONE;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_outer <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_driver.sv
// Scoreboard bench for counter_driver: 4x8 sweeps with GAP=2, plus a 1-sweep GAP=0 instance.
// Expected sweep indices and run totals are queued at go and checked at cnt_start/done.
module tb_counter_driver;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_driver_if #(.CW(CW)) ifa ();
  counter_driver_if #(.CW(CW)) ifb ();

  counter_driver #(
    .CW(CW), .OUTER_MAX(4), .GAP(2), .TIMEOUT(64)
  ) u_a (
    .clk(clk), .rst(rst), .bus(ifa.master)
  );

  counter_driver #(
    .CW(CW), .OUTER_MAX(1), .GAP(0), .TIMEOUT(20)
  ) u_b (
    .clk(clk), .rst(rst), .bus(ifb.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counter model, MAX=8: done in the 8th enabled cycle.
  int ca = 0;
  always @(posedge clk) begin
    if (ifa.cnt_start) ca <= 0;
    else if (ifa.cnt_ena) ca <= (ca == 7) ? 0 : ca + 1;
  end
  assign ifa.cnt_done = ifa.cnt_ena && (ca == 7);

  // Stall toggles every 3 cycles while enabled.
  bit   tog_en = 1'b0;
  int   sc     = 0;
  logic st_r   = 1'b0;
  always @(posedge clk) begin
    sc <= (sc == 2) ? 0 : sc + 1;
    if (!tog_en) st_r <= 1'b0;
    else if (sc == 2) st_r <= ~st_r;
  end
  assign ifa.stall = st_r;

  logic frc_b = 1'b0;
  assign ifb.cnt_done = frc_b;

  typedef struct {
    int ena;
    int st;
  } run_t;

  logic [CW-1:0] q_out[$];
  run_t          q_run[$];
  run_t          r_run;
  bit            mon_on = 1'b0;
  int            ena_a  = 0;
  int            st_a   = 0;
  int            cyc    = 0;
  int            dcyc   = -1;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (ifa.stall) check("ena_vs_stall", ifa.cnt_ena, 0);
      if (ifa.cnt_ena) ena_a++;
      if (ifa.cnt_start) begin
        st_a++;
        check("start_expected", q_out.size() > 0, 1);
        if (q_out.size() > 0)
          check("outer_cnt", ifa.outer_cnt, q_out.pop_front());
        if (dcyc >= 0) check("gap_len", cyc - dcyc - 1, 2);
      end
      if (ifa.cnt_done) dcyc = cyc;
      if (ifa.done) begin
        check("done_expected", q_run.size() > 0, 1);
        if (q_run.size() > 0) begin
          r_run = q_run.pop_front();
          check("ena_total", ena_a, r_run.ena);
          check("start_total", st_a, r_run.st);
        end
        ena_a = 0;
        st_a  = 0;
        dcyc  = -1;
      end
    end
  end

  task automatic pulse_go_a();
    @(posedge clk); #1 ifa.go = 1'b1;
    @(posedge clk); #1 ifa.go = 1'b0;
  endtask

  task automatic go_a();
    for (int i = 0; i < 4; i++) q_out.push_back(CW'(i));
    q_run.push_back('{ena: 32, st: 4});
    pulse_go_a();
  endtask

  task automatic wait_done_a(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (ifa.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic quiet_a(input int n, output int act);
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifa.done || ifa.busy || ifa.cnt_start || ifa.cnt_ena) act++;
    end
  endtask

  bit ok;
  bit hit;
  int act;
  int n;

  initial begin
    rst       = 1'b0;
    ifa.go    = 1'b0;
    ifb.go    = 1'b0;
    ifb.stall = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start", ifa.cnt_start, 0);
    check("rst_ena", ifa.cnt_ena, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_outer", ifa.outer_cnt, 0);
`ifdef COUNTER_DRIVER_WDOG_EN
    check("rst_err", ifa.err, 0);
`endif
    rst = 1'b1;
    mon_on = 1'b1;

    // Plain run.
    go_a();
    @(negedge clk);
    check("t1_busy_after_go", ifa.busy, 1);
    check("t1_start_after_go", ifa.cnt_start, 1);
    wait_done_a(200, ok);
    check("t1_done_seen", ok, 1);
    check("t1_busy_at_done", ifa.busy, 0);
    check("t1_outer_at_done", ifa.outer_cnt, 0);
    quiet_a(10, act);
    check("t1_quiet_after", act, 0);

    // Stall toggling.
    tog_en = 1'b1;
    go_a();
    wait_done_a(400, ok);
    tog_en = 1'b0;
    check("t2_done_seen", ok, 1);
    quiet_a(10, act);
    check("t2_quiet_after", act, 0);

    // go while busy and go during FIN are dropped.
    go_a();
    repeat (5) @(negedge clk);
    pulse_go_a();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifa.cnt_done && ifa.outer_cnt == CW'(3)) begin
        hit = 1'b1;
        break;
      end
    end
    check("t3_last_sweep", hit, 1);
    @(posedge clk); #1 ifa.go = 1'b1;
    @(posedge clk); #1 ifa.go = 1'b0;
    wait_done_a(5, ok);
    check("t3_done_seen", ok, 1);
    quiet_a(25, act);
    check("t3_no_second_run", act, 0);

    // Reset mid-run at outer_cnt=2.
    mon_on = 1'b0;
    pulse_go_a();
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifa.outer_cnt == CW'(2)) begin
        hit = 1'b1;
        break;
      end
    end
    check("t4_reached_2", hit, 1);
    #2 rst = 1'b0;
    #1;
    check("t4_start", ifa.cnt_start, 0);
    check("t4_ena", ifa.cnt_ena, 0);
    check("t4_busy", ifa.busy, 0);
    check("t4_done", ifa.done, 0);
    check("t4_outer", ifa.outer_cnt, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    quiet_a(30, act);
    check("t4_idle_no_go", act, 0);
    ena_a  = 0;
    st_a   = 0;
    dcyc   = -1;
    mon_on = 1'b1;
    go_a();
    wait_done_a(200, ok);
    check("t4_rerun_done", ok, 1);

    // OUTER_MAX=1, GAP=0; cnt_done arrives with stall high.
    @(posedge clk); #1 ifb.go = 1'b1;
    @(posedge clk); #1 ifb.go = 1'b0;
    @(negedge clk);
    check("t5_start", ifb.cnt_start, 1);
    check("t5_busy", ifb.busy, 1);
    check("t5_ena_in_start", ifb.cnt_ena, 0);
    @(posedge clk); #1 ifb.stall = 1'b1; frc_b = 1'b1;
    @(negedge clk);
    check("t5_ena_stalled", ifb.cnt_ena, 0);
    @(posedge clk); #1 ifb.stall = 1'b0; frc_b = 1'b0;
    @(negedge clk);
    check("t5_done_fin", ifb.done, 0);
    check("t5_no_restart", ifb.cnt_start, 0);
    @(negedge clk);
    check("t5_done", ifb.done, 1);
    check("t5_busy_low", ifb.busy, 0);
    @(negedge clk);
    check("t5_done_1cyc", ifb.done, 0);

`ifdef COUNTER_DRIVER_WDOG_EN
    // Watchdog with cnt_done held low.
    @(posedge clk); #1 ifb.go = 1'b1;
    @(posedge clk); #1 ifb.go = 1'b0;
    n   = 0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifb.err) begin
        hit = 1'b1;
        break;
      end
      if (ifb.cnt_ena) n++;
    end
    check("t6_err_set", hit, 1);
    check("t6_ena_cycles", n, 20);
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifb.done) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_done_after_err", ok, 1);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", ifb.err, 1);
`endif

    repeat (2) @(negedge clk);
    check("sb_outer_drained", q_out.size(), 0);
    check("sb_run_drained", q_run.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
